// File: rtl/rcc_pkg.sv
// Shared types and constants for the RCC reset sequencer.
// State encoding, domain bit map, cause bit map, counter width helper.
package rcc_pkg;

    typedef enum logic [2:0] {
        HOLD,
        SYNC_LOCK,
        REL_SYS,
        REL_APB,
        REL_ETH,
        RUN
    } rst_state_t;

    localparam int NUM_DOM    = 6;
    localparam int DOM_SYS    = 0;
    localparam int DOM_APB0   = 1;
    localparam int DOM_APB1   = 2;
    localparam int DOM_APB2   = 3;
    localparam int DOM_ETH_TX = 4;
    localparam int DOM_ETH_RX = 5;

    localparam int NUM_CAUSE  = 3;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_LOCK = 1;
    localparam int CAUSE_SYS  = 2;

    // Width of a counter that must hold 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcc_rst_stretch.sv
// Per-domain software-reset pulse stretcher.
// Ports: module_clk, module_rstn (sync, active-low), start (restart pulse),
// kill (abort, wins over start), rstn_o (registered active-low reset).
module rcc_rst_stretch
    import rcc_pkg::*;
#(
    parameter int LEN = 8
) (
    input  logic module_clk,
    input  logic module_rstn,
    input  logic start,
    input  logic kill,
    output logic rstn_o
);

    localparam int            CW   = cnt_width(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [CW-1:0] cnt;

    // A start while already low restarts the count, so the low time
    // extends to LEN cycles after the most recent request.
    always_ff @(posedge module_clk) begin
        if (!module_rstn) begin
            rstn_o <= 1'b1;
            cnt    <= '0;
        end else if (kill) begin
            rstn_o <= 1'b1;
            cnt    <= '0;
        end else if (start) begin
            rstn_o <= 1'b0;
            cnt    <= '0;
        end else if (!rstn_o) begin
            if (cnt == LAST) begin
                rstn_o <= 1'b1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rcc_rst_seq.sv
// RCC reset sequencer: qualifies PLL lock, releases sys/APB/ETH resets in
// order, aborts on lock loss or soft reset, and stretches per-domain SW resets.
// Ports: module_clk, module_rstn (sync, active-low), pll_locked (async),
// sys_rst_req, sw_rst_req[5:0], cause_clr; dom_rstn[5:0], rst_done, rst_cause[2:0].
module rcc_rst_seq
    import rcc_pkg::*;
#(
    parameter int LOCK_CNT   = 256,
    parameter int STAGE_GAP  = 16,
    parameter int SW_RST_LEN = 8
) (
    input  logic                 module_clk,
    input  logic                 module_rstn,
    input  logic                 pll_locked,
    input  logic                 sys_rst_req,
    input  logic [NUM_DOM-1:0]   sw_rst_req,
    input  logic                 cause_clr,
    output logic [NUM_DOM-1:0]   dom_rstn,
    output logic                 rst_done,
    output logic [NUM_CAUSE-1:0] rst_cause
);

    localparam int            LW        = cnt_width(LOCK_CNT);
    localparam int            GW        = cnt_width(STAGE_GAP);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    logic [1:0]           sync;
    logic                 lock_s;

    rst_state_t           state;
    rst_state_t           state_n;
    logic [LW-1:0]        lock_cnt;
    logic [LW-1:0]        lock_cnt_n;
    logic [GW-1:0]        gap_cnt;
    logic [GW-1:0]        gap_cnt_n;
    logic [NUM_DOM-1:0]   stage_rstn;
    logic [NUM_DOM-1:0]   stage_rstn_n;
    logic                 done_n;
    logic [NUM_CAUSE-1:0] cause_n;

    logic                 lock_loss;
    logic                 sys_hit;
    logic                 abort;
    logic [NUM_DOM-1:0]   sw_go;
    logic [NUM_DOM-1:0]   str_rstn;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge module_clk) begin
        if (!module_rstn) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pll_locked};
        end
    end

    assign lock_s = sync[1];

    // Lock loss only aborts once a release has begun; inside SYNC_LOCK
    // a low lock_s just restarts qualification.
    assign lock_loss = (state != HOLD) && (state != SYNC_LOCK) && !lock_s;
    assign sys_hit   = (state != HOLD) && sys_rst_req;
    assign abort     = lock_loss || sys_hit;

    always_ff @(posedge module_clk) begin
        if (!module_rstn) begin
            state      <= HOLD;
            lock_cnt   <= '0;
            gap_cnt    <= '0;
            stage_rstn <= '0;
            rst_done   <= 1'b0;
            rst_cause  <= NUM_CAUSE'(1 << CAUSE_POR);
        end else begin
            state      <= state_n;
            lock_cnt   <= lock_cnt_n;
            gap_cnt    <= gap_cnt_n;
            stage_rstn <= stage_rstn_n;
            rst_done   <= done_n;
            rst_cause  <= cause_n;
        end
    end

    always_comb begin
        state_n      = state;
        lock_cnt_n   = lock_cnt;
        gap_cnt_n    = gap_cnt;
        stage_rstn_n = stage_rstn;
        done_n       = rst_done;
        cause_n      = cause_clr ? '0 : rst_cause;

        // New causes are OR-ed in after the clear so they survive it.
        if (lock_loss) begin
            cause_n[CAUSE_LOCK] = 1'b1;
        end
        if (sys_hit) begin
            cause_n[CAUSE_SYS] = 1'b1;
        end

        if (abort) begin
            state_n      = SYNC_LOCK;
            lock_cnt_n   = '0;
            gap_cnt_n    = '0;
            stage_rstn_n = '0;
            done_n       = 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    state_n    = SYNC_LOCK;
                    lock_cnt_n = '0;
                end
                SYNC_LOCK: begin
                    if (!lock_s) begin
                        lock_cnt_n = '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state_n               = REL_SYS;
                        lock_cnt_n            = '0;
                        gap_cnt_n             = '0;
                        stage_rstn_n[DOM_SYS] = 1'b1;
                    end else begin
                        lock_cnt_n = lock_cnt + LW'(1);
                    end
                end
                REL_SYS: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n   = REL_APB;
                        gap_cnt_n = '0;
                        stage_rstn_n[DOM_APB2:DOM_APB0] = 3'b111;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
                REL_APB: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n   = REL_ETH;
                        gap_cnt_n = '0;
                        stage_rstn_n[DOM_ETH_RX:DOM_ETH_TX] = 2'b11;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
                REL_ETH: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n   = RUN;
                        gap_cnt_n = '0;
                        done_n    = 1'b1;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end
                RUN: begin
                    done_n = 1'b1;
                end
                default: begin
                    state_n      = HOLD;
                    lock_cnt_n   = '0;
                    gap_cnt_n    = '0;
                    stage_rstn_n = '0;
                    done_n       = 1'b0;
                end
            endcase
        end
    end

    // Software requests are honoured only in RUN and never on an abort edge.
    assign sw_go = sw_rst_req & {NUM_DOM{(state == RUN) && !abort}};

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_str
        rcc_rst_stretch #(
            .LEN(SW_RST_LEN)
        ) u_str (
            .module_clk (module_clk),
            .module_rstn(module_rstn),
            .start      (sw_go[i]),
            .kill       (abort),
            .rstn_o     (str_rstn[i])
        );
    end

    // Both terms are flop outputs; no input reaches dom_rstn combinationally.
    assign dom_rstn = stage_rstn & str_rstn;

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Self-checking bench for rcc_rst_seq (LOCK_CNT=4, STAGE_GAP=2, SW_RST_LEN=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rcc_rst_seq;

    logic       clk;
    logic       rstn;
    logic       pll;
    logic       sys_req;
    logic [5:0] sw_req;
    logic       clr;
    logic [5:0] dom_rstn;
    logic       rst_done;
    logic [2:0] rst_cause;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pll;
        logic       sys;
        logic [5:0] sw;
        logic       clr;
        logic [5:0] dom;
        logic       done;
        logic [2:0] cause;
    } vec_t;

    vec_t tbl[$];

    rcc_rst_seq #(
        .LOCK_CNT  (4),
        .STAGE_GAP (2),
        .SW_RST_LEN(3)
    ) dut (
        .module_clk (clk),
        .module_rstn(rstn),
        .pll_locked (pll),
        .sys_rst_req(sys_req),
        .sw_rst_req (sw_req),
        .cause_clr  (clr),
        .dom_rstn   (dom_rstn),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [5:0] d,
                       input logic dn, input logic [2:0] c);
        checks++;
        if (dom_rstn !== d || rst_done !== dn || rst_cause !== c) begin
            errors++;
            $display("FAIL %s: got dom=%b done=%b cause=%b, want dom=%b done=%b cause=%b",
                     nm, dom_rstn, rst_done, rst_cause, d, dn, c);
        end
    endtask

    // Expected outputs n edges after lock qualification starts from zero.
    function automatic logic [5:0] pu_dom(input int n);
        if (n >= 9) return 6'b111111;
        if (n >= 7) return 6'b001111;
        if (n >= 5) return 6'b000001;
        return 6'b000000;
    endfunction

    function automatic logic pu_done(input int n);
        return n >= 11;
    endfunction

    task automatic add(input logic p, input logic s, input logic [5:0] w,
                       input logic c, input logic [5:0] d, input logic dn,
                       input logic [2:0] ca);
        vec_t v;
        v.pll = p; v.sys = s; v.sw = w; v.clr = c;
        v.dom = d; v.done = dn; v.cause = ca;
        tbl.push_back(v);
    endtask

    initial begin
        rstn = 1'b0; pll = 1'b1; sys_req = 1'b0; sw_req = '0; clr = 1'b0;

        // Power-up E0..E12, then software resets in RUN E13..E27.
        for (int n = 0; n <= 12; n++)
            add(1, 0, 6'b000000, 0, pu_dom(n), pu_done(n), 3'b001);
        add(1, 0, 6'b010000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111111, 1, 3'b001);
        add(1, 0, 6'b010000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b010000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b101111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111111, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111111, 1, 3'b001);
        add(1, 0, 6'b000011, 0, 6'b111100, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111100, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111100, 1, 3'b001);
        add(1, 0, 6'b000000, 0, 6'b111111, 1, 3'b001);

        step();
        step();
        chk("reset", 6'b000000, 0, 3'b001);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            pll = tbl[i].pll; sys_req = tbl[i].sys;
            sw_req = tbl[i].sw; clr = tbl[i].clr;
            step();
            chk($sformatf("tbl_e%0d", i), tbl[i].dom, tbl[i].done, tbl[i].cause);
        end
        sw_req = '0;

        // Lock loss coinciding with sys_rst_req, then clear plus new request.
        pll = 1'b0;
        step(); chk("sim_l1", 6'b111111, 1, 3'b001);
        step(); chk("sim_l2", 6'b111111, 1, 3'b001);
        sys_req = 1'b1;
        step(); chk("sim_both", 6'b000000, 0, 3'b111);
        clr = 1'b1;
        step(); chk("clr_and_sys", 6'b000000, 0, 3'b100);
        clr = 1'b0; sys_req = 1'b0;
        step(); chk("cause_sticky", 6'b000000, 0, 3'b100);

        // One-cycle lock glitch at j=3 delays release by 4 edges.
        for (int j = 0; j <= 15; j++) begin
            pll = (j == 3) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("glitch_j%0d", j), pu_dom(j - 4), pu_done(j - 4), 3'b100);
        end

        // Lock loss in RUN: three-edge response, then full re-sequence.
        clr = 1'b1;
        step(); chk("clr", 6'b111111, 1, 3'b000);
        clr = 1'b0;
        pll = 1'b0;
        step(); chk("ll_e1", 6'b111111, 1, 3'b000);
        step(); chk("ll_e2", 6'b111111, 1, 3'b000);
        step(); chk("ll_e3", 6'b000000, 0, 3'b010);
        pll = 1'b1;
        for (int j = 0; j <= 11; j++) begin
            step();
            chk($sformatf("relock_j%0d", j), pu_dom(j), pu_done(j), 3'b010);
        end

        // sys_rst_req abort, then software request during REL_APB ignored.
        sys_req = 1'b1;
        step(); chk("sys_a0", 6'b000000, 0, 3'b110);
        sys_req = 1'b0;
        for (int a = 1; a <= 6; a++) begin
            step();
            chk($sformatf("sys_a%0d", a), pu_dom(a + 1), 0, 3'b110);
        end
        sw_req = 6'b111111;
        step(); chk("sw_in_apb", 6'b001111, 0, 3'b110);
        sw_req = '0;
        step(); chk("sys_a8", 6'b111111, 0, 3'b110);
        step(); chk("sys_a9", 6'b111111, 0, 3'b110);
        step(); chk("sys_a10", 6'b111111, 1, 3'b110);

        // Active stretch killed by abort; APB0 follows the normal sequence.
        sw_req = 6'b000010;
        step(); chk("kill_b0", 6'b111101, 1, 3'b110);
        sys_req = 1'b1;
        step(); chk("kill_b1", 6'b000000, 0, 3'b110);
        sys_req = 1'b0; sw_req = '0;
        for (int k = 2; k <= 11; k++) begin
            step();
            chk($sformatf("kill_b%0d", k), pu_dom(k), pu_done(k), 3'b110);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcc_rst_seq.md
# rcc_rst_seq

Reset sequencer for the RCC. It replaces the flat `RSTN & pll_locked` gating of the root resets with a controlled sequence:

- qualify PLL lock;
- release domain resets in a fixed order: sys, then APB, then ETH;
- re-enter reset on lock loss or a whole-chip soft-reset request;
- allow per-domain software resets.

Outputs are raw, active-low, and in the `module_clk` domain. Each consuming domain re-synchronises deassertion locally.

## Interface

Parameters:
- `LOCK_CNT`, default 256: consecutive synchronised-lock cycles required before the first release.
- `STAGE_GAP`, default 16: cycles between release stages; also the dwell time before `rst_done`.
- `SW_RST_LEN`, default 8: cycles a per-domain software reset is held low.

Ports:
- `module_clk`  in  1: sequencer clock. One clock; this is the always-on source.
- `module_rstn`  in  1: reset, synchronous, active-low.
- `pll_locked`  in  1: PLL lock, asynchronous to `module_clk`. Passes through a 2-flop synchroniser to become `lock_s`.
- `sys_rst_req`  in  1: whole-chip soft reset request, single-cycle pulse.
- `sw_rst_req`  in  6: per-domain soft reset pulses.
- `cause_clr`  in  1: clears `rst_cause`.
- `dom_rstn`  out  6: domain resets. Bit map: [0] sys, [1] apb0, [2] apb1, [3] apb2, [4] eth_pe_tx, [5] eth_pe_rx.
- `rst_done`  out  1: high while in RUN.
- `rst_cause`  out  3: sticky cause bits. [0] power-on, [1] lock loss, [2] `sys_rst_req`.

## Operation

Reset values:
- state = HOLD
- `dom_rstn` = 6'b000000
- `rst_done` = 0
- `rst_cause` = 3'b001
- all counters = 0
- synchroniser flops = 0

States and transitions:
- **HOLD**: moves to SYNC_LOCK on the next edge, unconditionally.
- **SYNC_LOCK**:
  - `lock_cnt` increments on each edge with `lock_s`=1 and clears to 0 on `lock_s`=0.
  - On an edge where `lock_s`=1 and `lock_cnt`==LOCK_CNT-1: go to REL_SYS and set `dom_rstn[0]`=1.
- **REL_SYS**: after STAGE_GAP cycles, go to REL_APB and set `dom_rstn[3:1]`=1.
- **REL_APB**: after STAGE_GAP cycles, go to REL_ETH and set `dom_rstn[5:4]`=1.
- **REL_ETH**: after STAGE_GAP cycles, go to RUN and set `rst_done`=1.
- The gap counter clears on every state entry.

Abort from any state except HOLD:
- Trigger: `lock_s`=0 (outside SYNC_LOCK), or `sys_rst_req`=1.
- Next edge: `dom_rstn`=0, `rst_done`=0, state=SYNC_LOCK, `lock_cnt`=0, all software-reset counters=0.
- Cause bits: set bit 1 for lock loss and/or bit 2 for `sys_rst_req`. If both occur in the same cycle, both bits are set.

Software reset, RUN only:
- `sw_rst_req[i]` drives `dom_rstn[i]`=0 from the next edge for exactly SW_RST_LEN cycles, then back to 1.
- A re-pulse while the reset is active restarts the count.
- Domains are independent; simultaneous requests are all honoured.
- `rst_done` stays 1 during a software reset.
- Requests outside RUN are ignored.

Priority: abort > software reset. Within `rst_cause`, set beats `cause_clr` in the same cycle.

`cause_clr`: clears all bits of `rst_cause` on the next edge. New causes raised in the same cycle remain set.

## Timing

Edge numbering: E0 is the first edge with `module_rstn`=1; `pll_locked` is steady high.
- `lock_s`=1 after E1.
- `dom_rstn[0]` rises after E(LOCK_CNT+1).
- `dom_rstn[3:1]` rises STAGE_GAP edges later.
- `dom_rstn[5:4]` rises a further STAGE_GAP edges later.
- `rst_done` rises a further STAGE_GAP edges later.

Latencies:
- Lock-loss response: 3 edges from the `pll_locked` fall (2 synchroniser edges + 1 edge to drive `dom_rstn`=0).
- `sys_rst_req` and `sw_rst_req` response: 1 edge.
- All outputs are registered. There is no combinational path from input to output.

## Structure

- Package `rcc_pkg` holds:
  - state enum: HOLD, SYNC_LOCK, REL_SYS, REL_APB, REL_ETH, RUN;
  - domain index constants DOM_SYS..DOM_ETH_RX;
  - cause bit positions CAUSE_POR, CAUSE_LOCK, CAUSE_SYS.
- Sub-module `rcc_rst_stretch`: per-domain software-reset pulse stretcher, instantiated 6×. Ports: `module_clk`, `module_rstn`, `start`, `kill`, `rstn_o`.
- Counter widths are `$clog2` of their parameter, with a minimum of 1.

## Test plan

Bench parameters: LOCK_CNT=4, STAGE_GAP=2, SW_RST_LEN=3.

1. **Power-up release order**: `pll_locked` held 1 → `dom_rstn` reads 000001 after E5, 001111 after E7, 111111 after E9; `rst_done`=1 after E11; `rst_cause`=001.
2. **Lock glitch during qualification**: `pll_locked` low for 1 cycle during SYNC_LOCK → `lock_cnt` restarts; the release edge shifts by the glitch position + 1; `rst_cause` unchanged.
3. **Lock loss in RUN**: drop `pll_locked` → all `dom_rstn`=0 and `rst_done`=0 three edges later; `rst_cause[1]`=1; after lock returns, the full sequence repeats with power-up timing.
4. **Simultaneous causes**: `sys_rst_req` pulse in the same cycle as the synchronised lock loss → `rst_cause`=3'b111. With `cause_clr` and a new `sys_rst_req` in the same cycle → `rst_cause`=3'b100.
5. **Per-domain software reset in RUN**: `sw_rst_req`=6'b010000 → `dom_rstn[4]` low for exactly 3 cycles, other bits stay 1; re-pulse on cycle 2 → low for 2+3=5 cycles total.
6. **Software reset ignored / killed**: `sw_rst_req` during REL_APB → no effect. `sw_rst_req[1]` active in RUN when `sys_rst_req` arrives → abort wins, and `dom_rstn[1]` follows the full sequence with no leftover stretch.
